// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - parametrised square-wave and clock-enable tick divider
module tick_generator #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int OUT_HZ    = 1,
   parameter int FAST_MULT = 60,
   parameter int CNT_W     = 26
) (
   input  logic clk_50MHz,
   input  logic reset,
   input  logic enable,
   input  logic fast,
   input  logic sync_clr,
   output logic sig_out,
   output logic tick,
   output logic half_tick
);

   localparam int HALF_RAW  = CLK_HZ / (2 * OUT_HZ);
   localparam int HALF      = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int FAST_RAW  = HALF / FAST_MULT;
   localparam int FAST_HALF = (FAST_RAW < 1) ? 1 : FAST_RAW;

   // Terminal counts are LIM-1 so each half period spans exactly LIM enabled edges.
   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_HALF - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lim_tc;
   logic             sig_q, sig_d;
   logic             tick_q, tick_d;
   logic             half_q, half_d;

   always_comb begin
      lim_tc = fast ? FAST_TC : HALF_TC;
      cnt_d  = cnt_q;
      sig_d  = sig_q;
      tick_d = 1'b0;
      half_d = 1'b0;
      if (sync_clr) begin
         cnt_d = '0;
         sig_d = 1'b0;
      end else if (enable) begin
         // >= rather than == lets a switch into fast mode terminate at once instead of wrapping.
         if (cnt_q >= lim_tc) begin
            cnt_d  = '0;
            sig_d  = ~sig_q;
            half_d = 1'b1;
            tick_d = ~sig_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         sig_q  <= 1'b0;
         tick_q <= 1'b0;
         half_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sig_q  <= sig_d;
         tick_q <= tick_d;
         half_q <= half_d;
      end
   end

   assign sig_out   = sig_q;
   assign tick      = tick_q;
   assign half_tick = half_q;

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - self-checking bench for tick_generator
module tb_tick_generator;

   logic clk_50MHz = 1'b0;
   logic reset, enable, fast, sync_clr;
   logic sig_out, tick, half_tick;
   logic c_sig, c_tick, c_half;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: per instance, position within the current half period and output levels.
   int h [2];
   int fh[2];
   int mc[2];
   bit ms[2], mt[2], mh[2];

   always #5 clk_50MHz = ~clk_50MHz;

   tick_generator #(.CLK_HZ(20), .OUT_HZ(1), .FAST_MULT(5), .CNT_W(26)) u_dut (
      .clk_50MHz(clk_50MHz), .reset(reset), .enable(enable), .fast(fast),
      .sync_clr(sync_clr), .sig_out(sig_out), .tick(tick), .half_tick(half_tick)
   );

   tick_generator #(.CLK_HZ(4), .OUT_HZ(1), .FAST_MULT(60), .CNT_W(4)) u_clamp (
      .clk_50MHz(clk_50MHz), .reset(reset), .enable(enable), .fast(fast),
      .sync_clr(sync_clr), .sig_out(c_sig), .tick(c_tick), .half_tick(c_half)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 0; ms[i] = 0; mt[i] = 0; mh[i] = 0;
      end
   endtask

   task automatic model_edge(input bit en, input bit fs, input bit clr);
      int lim;
      for (int i = 0; i < 2; i++) begin
         mt[i] = 0;
         mh[i] = 0;
         lim = fs ? fh[i] : h[i];
         if (clr) begin
            mc[i] = 0;
            ms[i] = 0;
         end else if (en) begin
            if (mc[i] + 1 >= lim) begin
               mh[i] = 1;
               mt[i] = !ms[i];
               ms[i] = !ms[i];
               mc[i] = 0;
            end else begin
               mc[i] = mc[i] + 1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".sig"},   sig_out,   ms[0]);
      chk({tag, ".tick"},  tick,      mt[0]);
      chk({tag, ".half"},  half_tick, mh[0]);
      chk({tag, ".csig"},  c_sig,     ms[1]);
      chk({tag, ".ctick"}, c_tick,    mt[1]);
      chk({tag, ".chalf"}, c_half,    mh[1]);
   endtask

   // Called at a falling edge; drives inputs, advances one rising edge, checks, returns at the next falling edge.
   task automatic step(input bit en, input bit fs, input bit clr, input string tag);
      enable = en; fast = fs; sync_clr = clr;
      @(posedge clk_50MHz);
      if (reset) model_reset();
      else model_edge(en, fs, clr);
      #1;
      check_all(tag);
      @(negedge clk_50MHz);
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all({tag, ".imm"});
      @(posedge clk_50MHz);
      #1;
      check_all({tag, ".held"});
      @(negedge clk_50MHz);
      reset = 1'b0;
   endtask

   initial begin
      int first_tick, hi_cnt, n_tick, n_half, found;
      bit r_en, r_fs, r_clr;

      h[0]  = 20 / (2 * 1);
      fh[0] = (h[0] / 5 < 1) ? 1 : h[0] / 5;
      h[1]  = 4 / (2 * 1);
      fh[1] = (h[1] / 60 < 1) ? 1 : h[1] / 60;
      model_reset();

      // 1: reset state, then first toggle after 10 edges and a 20-edge period
      reset = 1'b1; enable = 1'b1; fast = 1'b0; sync_clr = 1'b0;
      @(negedge clk_50MHz);
      step(1, 0, 0, "s1_rst");
      step(1, 0, 0, "s1_rst");
      reset = 1'b0;
      first_tick = -1; hi_cnt = 0; n_tick = 0; n_half = 0;
      for (int e = 1; e <= 20; e++) begin
         step(1, 0, 0, "s1_run");
         if (tick === 1'b1 && first_tick < 0) first_tick = e;
         if (sig_out === 1'b1) hi_cnt++;
         if (tick === 1'b1) n_tick++;
         if (half_tick === 1'b1) n_half++;
      end
      chk_int("s1_first_tick_edge", first_tick, 10);
      chk_int("s1_high_edges", hi_cnt, 10);
      chk_int("s1_tick_count", n_tick, 1);
      chk_int("s1_half_count", n_half, 2);

      // 2: hold at cnt=4 for 7 cycles, then toggle on 6th enabled edge
      for (int e = 0; e < 4; e++) step(1, 0, 0, "s2_pre");
      for (int e = 0; e < 7; e++) step(0, 0, 0, "s2_hold");
      found = -1;
      for (int e = 1; e <= 30; e++) begin
         step(1, 0, 0, "s2_run");
         if (half_tick === 1'b1) begin
            found = e;
            break;
         end
      end
      chk_int("s2_toggle_edge", found, 6);

      // 3: fast mode from reset
      async_reset("s3_rst");
      n_tick = 0; n_half = 0;
      for (int e = 0; e < 16; e++) begin
         step(1, 1, 0, "s3_fast");
         if (tick === 1'b1) n_tick++;
         if (half_tick === 1'b1) n_half++;
      end
      chk_int("s3_tick_count", n_tick, 4);
      chk_int("s3_half_count", n_half, 8);

      // 4: raise fast at cnt=7
      step(1, 0, 1, "s4_clr");
      for (int e = 0; e < 7; e++) step(1, 0, 0, "s4_pre");
      step(1, 1, 0, "s4_switch");
      chk("s4_switch_half", half_tick, 1'b1);
      chk("s4_switch_sig", sig_out, 1'b1);
      step(1, 1, 0, "s4_f1");
      chk("s4_f1_half", half_tick, 1'b0);
      step(1, 1, 0, "s4_f2");
      chk("s4_f2_half", half_tick, 1'b1);

      // 5: sync clear with sig_out high while disabled, then async reset mid-count
      step(1, 0, 1, "s5_clr0");
      for (int e = 0; e < 16; e++) step(1, 0, 0, "s5_pre");
      chk("s5_pre_sig", sig_out, 1'b1);
      step(0, 0, 1, "s5_clr");
      chk("s5_clr_sig", sig_out, 1'b0);
      chk("s5_clr_tick", tick, 1'b0);
      for (int e = 0; e < 12; e++) step(1, 0, 0, "s5_run");
      chk("s5_run_sig", sig_out, 1'b1);
      async_reset("s5_arst");
      chk("s5_arst_sig", sig_out, 1'b0);

      // Randomized mix of enable, fast, clears and async resets
      r_fs = 0;
      for (int n = 0; n < 3000; n++) begin
         r_en  = ($urandom % 8) != 0;
         if (($urandom % 16) == 0) r_fs = ~r_fs;
         r_clr = ($urandom % 64) == 0;
         if (($urandom % 300) == 0) async_reset("rnd_arst");
         else step(r_en, r_fs, r_clr, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
